// File: rtl/bp_me_axil_master.sv
// ============================================================================
// Module   : bp_me_axil_master
// Brief    : BedRock uncached I/O command -> single AXI4-Lite manager access.
//            Optional error counter: define BP_ME_AXIL_MASTER_ERR_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_me_axil_master #(
    parameter int paddr_width_p     = 40,
    parameter int did_width_p       = 4,
    parameter int lce_id_width_p    = 8,
    parameter int lce_assoc_p       = 8,
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    localparam int axil_mask_width_lp  = axil_data_width_p >> 3,
    localparam int payload_width_lp    = did_width_p + lce_id_width_p + $clog2(lce_assoc_p),
    localparam int mem_header_width_lp = payload_width_lp + 3 + paddr_width_p + 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [mem_header_width_lp-1:0] io_cmd_header_i,
    input  logic [axil_data_width_p-1:0]   io_cmd_data_i,
    input  logic                           io_cmd_v_i,
    output logic                           io_cmd_ready_and_o,
    input  logic                           io_cmd_last_i,

    output logic [mem_header_width_lp-1:0] io_resp_header_o,
    output logic [axil_data_width_p-1:0]   io_resp_data_o,
    output logic                           io_resp_v_o,
    input  logic                           io_resp_ready_and_i,
    output logic                           io_resp_last_o,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,

    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_mask_width_lp-1:0]  m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,

    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,

    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic [2:0]                     m_axil_arprot_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,

    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o,

    output logic [15:0]                    err_count_o
);

    localparam int         c_LG_MASK   = $clog2(axil_mask_width_lp);
    localparam logic [2:0] c_MAX_LG    = 3'(c_LG_MASK);
    localparam logic [3:0] c_MSG_UC_RD = 4'd2;

    typedef enum logic [2:0] {
        e_ready     = 3'd0,
        e_rd_addr   = 3'd1,
        e_rd_data   = 3'd2,
        e_wr        = 3'd3,
        e_wr_resp   = 3'd4,
        e_resp      = 3'd5
    } state_e;

    state_e r_state, w_state_nxt;

    logic [mem_header_width_lp-1:0] r_hdr;
    logic [axil_data_width_p-1:0]   r_wdata;
    logic [axil_mask_width_lp-1:0]  r_strb;
    logic [axil_addr_width_p-1:0]   r_addr;
    logic [c_LG_MASK-1:0]           r_off;
    logic [c_LG_MASK-1:0]           r_bytes_m1;
    logic [axil_data_width_p-1:0]   r_rdata;
    logic                           r_aw_done;
    logic                           r_w_done;

    logic                           w_cmd_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
    logic [3:0]                     w_msg;
    logic [2:0]                     w_size;
    logic [2:0]                     w_size_lg;
    logic [axil_addr_width_p-1:0]   w_addr;
    logic [c_LG_MASK-1:0]           w_bytes_m1;
    logic [c_LG_MASK-1:0]           w_off;
    logic [axil_mask_width_lp-1:0]  w_strb;
    logic [axil_data_width_p-1:0]   w_resp_data;

    assign w_msg     = io_cmd_header_i[3:0];
    assign w_addr    = io_cmd_header_i[8 +: axil_addr_width_p];
    assign w_size    = io_cmd_header_i[8 + paddr_width_p +: 3];
    assign w_size_lg = (w_size > c_MAX_LG) ? c_MAX_LG : w_size;

    // bytes-1 is a mask of the low size_lg bits; lanes sharing the aligned offset get strobed.
    always_comb begin
        w_bytes_m1 = '0;
        for (int b = 0; b < c_LG_MASK; b++) begin
            w_bytes_m1[b] = (b < int'(w_size_lg));
        end
        w_off  = w_addr[c_LG_MASK-1:0] & ~w_bytes_m1;
        w_strb = '0;
        for (int i = 0; i < axil_mask_width_lp; i++) begin
            w_strb[i] = ((i & ~int'(w_bytes_m1)) == int'(w_off));
        end
    end

    // Output byte i takes the field byte (i mod bytes), which replicates the field.
    always_comb begin
        w_resp_data = '0;
        for (int i = 0; i < axil_mask_width_lp; i++) begin
            w_resp_data[8*i +: 8] = r_rdata[8*(int'(r_off) | (i & int'(r_bytes_m1))) +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_ready;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        io_cmd_ready_and_o = 1'b0;
        m_axil_arvalid_o   = 1'b0;
        m_axil_rready_o    = 1'b0;
        m_axil_awvalid_o   = 1'b0;
        m_axil_wvalid_o    = 1'b0;
        m_axil_bready_o    = 1'b0;
        io_resp_v_o        = 1'b0;
        case (r_state)
            e_ready: begin
                io_cmd_ready_and_o = reset_n_i;
                if (io_cmd_v_i && reset_n_i) begin
                    w_state_nxt = (w_msg == c_MSG_UC_RD) ? e_rd_addr : e_wr;
                end
            end
            e_rd_addr: begin
                m_axil_arvalid_o = 1'b1;
                if (m_axil_arready_i) w_state_nxt = e_rd_data;
            end
            e_rd_data: begin
                m_axil_rready_o = 1'b1;
                if (m_axil_rvalid_i) w_state_nxt = e_resp;
            end
            e_wr: begin
                m_axil_awvalid_o = !r_aw_done;
                m_axil_wvalid_o  = !r_w_done;
                if ((r_aw_done || m_axil_awready_i) && (r_w_done || m_axil_wready_i)) begin
                    w_state_nxt = e_wr_resp;
                end
            end
            e_wr_resp: begin
                m_axil_bready_o = 1'b1;
                if (m_axil_bvalid_i) w_state_nxt = e_resp;
            end
            e_resp: begin
                io_resp_v_o = 1'b1;
                if (io_resp_ready_and_i) w_state_nxt = e_ready;
            end
            default: w_state_nxt = e_ready;
        endcase
    end

    assign w_cmd_hs = io_cmd_v_i && io_cmd_ready_and_o;
    assign w_aw_hs  = m_axil_awvalid_o && m_axil_awready_i;
    assign w_w_hs   = m_axil_wvalid_o && m_axil_wready_i;
    assign w_r_hs   = m_axil_rready_o && m_axil_rvalid_i;
    assign w_b_hs   = m_axil_bready_o && m_axil_bvalid_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hdr      <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_addr     <= '0;
            r_off      <= '0;
            r_bytes_m1 <= '0;
            r_rdata    <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_hdr      <= io_cmd_header_i;
                r_wdata    <= io_cmd_data_i;
                r_strb     <= w_strb;
                r_addr     <= w_addr;
                r_off      <= w_off;
                r_bytes_m1 <= w_bytes_m1;
                r_rdata    <= '0;
                r_aw_done  <= 1'b0;
                r_w_done   <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_r_hs)  r_rdata   <= m_axil_rdata_i;
        end
    end

    assign m_axil_awaddr_o  = r_addr;
    assign m_axil_araddr_o  = r_addr;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_wdata_o   = r_wdata;
    assign m_axil_wstrb_o   = r_strb;
    assign io_resp_header_o = r_hdr;
    assign io_resp_data_o   = w_resp_data;
    assign io_resp_last_o   = io_resp_v_o;

`ifdef BP_ME_AXIL_MASTER_ERR_CNT_EN
    logic        w_err_ev;
    logic [15:0] r_err_cnt;

    assign w_err_ev = (w_r_hs && (m_axil_rresp_i != 2'b00))
                   || (w_b_hs && (m_axil_bresp_i != 2'b00));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err_cnt <= '0;
        end else if (w_err_ev && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_count_o = r_err_cnt;

    logic w_unused;
    assign w_unused = io_cmd_last_i;
`else
    assign err_count_o = 16'h0;

    logic w_unused;
    assign w_unused = ^{io_cmd_last_i, m_axil_rresp_i, m_axil_bresp_i, w_b_hs};
`endif

endmodule

`default_nettype wire

// File: doc/bp_me_axil_master.md
Name: bp_me_axil_master

Overview:
- Bridge from the BedRock I/O command network to an AXI4-Lite manager port.
- Accepts single-beat uncached BedRock mem commands (uc_rd / uc_wr) and issues one AXI4-Lite read or write per command. Returns the matching BedRock response.
- Used to reach AXI-Lite peripherals (UART, PLIC, debug regs) from BP I/O; the outbound counterpart of the AXI-Lite-to-BedRock client path.
- Strictly one transaction outstanding.

Parameters:
- bp_params_p, e_bp_default_cfg, BP configuration; supplies paddr_width_p, did_width_p, lce_id_width_p, lce_assoc_p and therefore mem_header_width_lp.
- axil_data_width_p, 32, AXI data width in bits; legal values 32 or 64.
- axil_addr_width_p, 32, AXI address width; the lower bits of header addr are used.
- axil_mask_width_lp (localparam), axil_data_width_p>>3, strobe width.

Ports:
- clk_i  in  1  single clock
- reset_n_i  in  1  asynchronous active-low reset
- io_cmd_header_i  in  mem_header_width_lp  BedRock command header
- io_cmd_data_i  in  axil_data_width_p  write data, BedRock-replicated
- io_cmd_v_i  in  1  command valid
- io_cmd_ready_and_o  out  1  command ready
- io_cmd_last_i  in  1  always equal to v; unused
- io_resp_header_o  out  mem_header_width_lp  response header
- io_resp_data_o  out  axil_data_width_p  read data
- io_resp_v_o  out  1  response valid
- io_resp_ready_and_i  in  1  response ready
- io_resp_last_o  out  1  equals io_resp_v_o
- m_axil_awaddr_o / awprot_o[2:0] / awvalid_o  out, awready_i  in  AXI write address channel
- m_axil_wdata_o / wstrb_o / wvalid_o  out, wready_i  in  AXI write data channel
- m_axil_bresp_i[1:0]  in, bvalid_i  in, bready_o  out  AXI write response channel
- m_axil_araddr_o / arprot_o[2:0] / arvalid_o  out, arready_i  in  AXI read address channel
- m_axil_rdata_i / rresp_i[1:0] / rvalid_i  in, rready_o  out  AXI read data channel
- err_count_o  out  16  saturating count of non-OKAY responses (see Optional Feature)

Behaviour:
- Reset: asynchronous on reset_n_i=0, effective immediately.
  - State returns to e_ready. Every valid and ready output is 0, except io_cmd_ready_and_o, which rises once reset deasserts.
  - Stored header, data and err_count_o clear to 0.
  - Any in-flight AXI transaction is abandoned; the peripheral side must be reset together with this block.
- FSM states: e_ready, e_rd_addr, e_rd_data, e_wr, e_wr_resp, e_resp.
- e_ready:
  - io_cmd_ready_and_o=1.
  - On v&ready, register header, data, wstrb and araddr/awaddr.
  - Next state is e_rd_addr for uc_rd, otherwise e_wr; every non-uc_rd msg_type is treated as a write.
- AXI outputs are registered; first valid appears in the cycle after acceptance.
- e_rd_addr: arvalid=1 until arready, then go to e_rd_data.
- e_rd_data:
  - rready=1.
  - On rvalid, capture rdata and rresp, then go to e_resp.
- e_wr:
  - awvalid and wvalid asserted together; each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - Both handshakes may occur in the same cycle.
  - When both are done, go to e_wr_resp.
- e_wr_resp:
  - bready=1.
  - On bvalid, capture bresp and go to e_resp.
- e_resp:
  - io_resp_v_o=1, with header equal to the stored command header unchanged (msg_type, addr, size, payload).
  - Held until io_resp_ready_and_i, then return to e_ready.
  - No bypass: minimum command-to-response latency is 3 cycles for reads and 3 for writes.
- arprot/awprot fixed at 3'b000.
- Strobe rule:
  - bytes = 1<<size, clamped to axil_mask_width_lp (size beyond bus width issues a full strobe at the aligned word).
  - wstrb = ((1<<bytes)-1) << (addr mod axil_mask_width_lp), with the offset aligned down to bytes.
  - wdata = io_cmd_data_i unchanged; it is already replicated.
- Read data rule:
  - field = rdata >> (8*offset), truncated to 8*bytes.
  - io_resp_data_o = field replicated to fill axil_data_width_p.
- Errors: bresp/rresp other than 2'b00 do not alter the response; the data is still returned.

Optional Feature:
- Macro name: BP_ME_AXIL_MASTER_ERR_CNT_EN.
- Defined: err_count_o increments by 1 on each accepted bresp/rresp not equal to OKAY, saturating at 16'hFFFF. Cleared only by reset.
- Undefined: err_count_o is tied to 16'h0 and no counter flops exist.

Test Plan:
- uc_rd size_4, addr 0x1000_0004, rdata 0xDEADBEEF, arready 1 cycle late -> araddr 0x1000_0004; response data 0xDEADBEEF, header equals the command header.
- uc_wr size_1, addr 0x...03, data 0x5A5A5A5A -> wstrb 4'b1000, wdata 0x5A5A5A5A; response after bvalid.
- uc_wr with awready in cycle N and wready in cycle N+3 -> awvalid drops after N, wvalid held until N+3, bready only afterwards.
- uc_rd size_2, addr offset 2, rdata 0x1234ABCD -> io_resp_data_o 0x12341234.
- io_resp_ready_and_i low for 5 cycles -> io_resp_v_o held stable and io_cmd_ready_and_o stays 0; next command accepted the cycle after the response handshake.
- With macro defined, three writes returning bresp 2'b10 -> err_count_o=3. reset_n_i pulsed low mid-e_rd_data -> all valids 0 immediately, err_count_o=0.
